// File: rtl/pp_pkg.sv
// Shared types and sizing for the path-parser hop dispatcher.
//   lane_state_t : per-lane sequencing state
//   NUM_LANES    : number of ping-pong hop FIFOs
//   *_DEF        : default widths for the dispatcher parameters
package pp_pkg;

    localparam int unsigned NUM_LANES   = 2;
    localparam int unsigned HOP_W_DEF   = 32;
    localparam int unsigned RCI_W_DEF   = 8;
    localparam int unsigned CNT_W_DEF   = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT_DONE,
        ST_DRAIN,
        ST_FLUSH
    } lane_state_t;

endpackage

// File: rtl/pp_hop_lane.sv
// One ping-pong lane: packet sequencing FSM, registered FIFO write port and
// the lane's ready term.
//   sel          : this lane owns the dispatch pointer
//   in_*         : upstream hop beat, meta_valid = RCI available
//   full/fullm1  : lane FIFO fill flags
//   parse_done   : parser finished this lane's packet
//   ready_c      : beat accept term (only non-zero when selected)
//   sop_take_c   : SOP+RCI consumed this cycle
//   pkt_end_c    : last beat of the packet taken, dispatch pointer moves on
//   drop_c       : beat discarded while draining
//   err_c        : protocol violation seen by this lane
//   fifo_*       : registered FIFO flush/write port
module pp_hop_lane
    import pp_pkg::*;
#(
    parameter int unsigned HOP_W = HOP_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sel,
    input  logic             in_valid,
    input  logic [HOP_W-1:0] in_data,
    input  logic             in_sop,
    input  logic             in_eop,
    input  logic             meta_valid,
    input  logic             full,
    input  logic             fullm1,
    input  logic             parse_done,
    output logic             ready_c,
    output logic             sop_take_c,
    output logic             pkt_end_c,
    output logic             drop_c,
    output logic             err_c,
    output logic             fifo_reset,
    output logic             fifo_wr,
    output logic [HOP_W-1:0] fifo_wdata
);

    lane_state_t      state_q, state_d;
    logic             wr_q, wr_d;
    logic [HOP_W-1:0] wdata_q, wdata_d;
    logic             reset_q, reset_d;
    logic             accept;

    // Next state, write register and handshake terms
    always_comb begin
        state_d    = state_q;
        wr_d       = 1'b0;
        wdata_d    = wdata_q;
        ready_c    = 1'b0;
        sop_take_c = 1'b0;
        pkt_end_c  = 1'b0;
        drop_c     = 1'b0;
        err_c      = 1'b0;
        accept     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // SOP beat and its RCI are taken together
                ready_c    = sel & meta_valid & in_valid & in_sop;
                sop_take_c = ready_c;
                accept     = ready_c;
                err_c      = parse_done;
                if (accept) begin
                    wr_d      = 1'b1;
                    wdata_d   = in_data;
                    pkt_end_c = in_eop;
                    state_d   = in_eop ? ST_WAIT_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                // fullm1 only matters while a write is still in flight
                ready_c = sel & ~full & ~(wr_q & fullm1);
                accept  = ready_c & in_valid;
                if (accept) begin
                    wr_d      = 1'b1;
                    wdata_d   = in_data;
                    err_c     = in_sop;
                    pkt_end_c = in_eop;
                end
                if (accept && in_eop) begin
                    state_d = parse_done ? ST_FLUSH : ST_WAIT_DONE;
                end else if (parse_done) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_WAIT_DONE: begin
                if (parse_done) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_DRAIN: begin
                // parser already done: swallow the rest of the packet
                ready_c = sel;
                accept  = ready_c & in_valid;
                drop_c  = accept;
                if (accept && in_eop) begin
                    pkt_end_c = 1'b1;
                    state_d   = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                err_c   = parse_done;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        reset_d = (state_d == ST_FLUSH);
    end

    // State and output registers; reset also flushes the FIFO once
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            reset_q <= 1'b1;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            reset_q <= reset_d;
        end
    end

    assign fifo_reset = reset_q;
    assign fifo_wr    = wr_q;
    assign fifo_wdata = wdata_q;

endmodule

// File: rtl/pp_hop_dispatch.sv
// Path-parser front end: steers hop packets alternately into two ping-pong
// hop FIFOs, writes one RCI per packet to the meta FIFO, keeps packet/drop
// statistics and a sticky protocol-error flag.
//   hop_in_*   : upstream hop stream (valid/ready, sop/eop)
//   meta_in_*  : RCI of the packet whose SOP is pending
//   hop_fifo_* : per-lane flush/write ports and fill flags
//   parse_done : per-lane parser completion pulse
//   pp_meta_*  : registered meta FIFO write
//   pkt_cnt, drop_cnt, err_sticky : statistics and error status
module pp_hop_dispatch
    import pp_pkg::*;
#(
    parameter int unsigned HOP_W = HOP_W_DEF,
    parameter int unsigned RCI_W = RCI_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hop_in_valid,
    input  logic [HOP_W-1:0] hop_in_data,
    input  logic             hop_in_sop,
    input  logic             hop_in_eop,
    output logic             hop_in_ready,
    input  logic             meta_in_valid,
    input  logic [RCI_W-1:0] meta_in_rci,
    output logic             meta_in_ready,
    output logic             hop_fifo_reset0,
    output logic             hop_fifo_reset1,
    output logic             hop_fifo_wr0,
    output logic             hop_fifo_wr1,
    output logic [HOP_W-1:0] hop_fifo_wdata0,
    output logic [HOP_W-1:0] hop_fifo_wdata1,
    input  logic             hop_fifo_full0,
    input  logic             hop_fifo_full1,
    input  logic             hop_fifo_fullm10,
    input  logic             hop_fifo_fullm11,
    input  logic             parse_done0,
    input  logic             parse_done1,
    output logic             pp_meta_valid,
    output logic [RCI_W-1:0] pp_meta_rci,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             err_sticky
);

    logic [NUM_LANES-1:0] full_v, fm1_v, pd_v;
    logic [NUM_LANES-1:0] ready_v, sop_take_v, end_v, drop_v, err_v;
    logic [NUM_LANES-1:0] fifo_reset_v, fifo_wr_v;
    logic [HOP_W-1:0]     wdata_v [NUM_LANES];

    logic             wptr_q, wptr_d;
    logic             meta_valid_q, meta_valid_d;
    logic [RCI_W-1:0] rci_q, rci_d;
    logic [CNT_W-1:0] pkt_q, pkt_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             err_q, err_d;

    assign full_v = {hop_fifo_full1, hop_fifo_full0};
    assign fm1_v  = {hop_fifo_fullm11, hop_fifo_fullm10};
    assign pd_v   = {parse_done1, parse_done0};

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        pp_hop_lane #(.HOP_W(HOP_W)) u_lane (
            .clk        (clk),
            .rst        (rst),
            .sel        (wptr_q == 1'(i)),
            .in_valid   (hop_in_valid),
            .in_data    (hop_in_data),
            .in_sop     (hop_in_sop),
            .in_eop     (hop_in_eop),
            .meta_valid (meta_in_valid),
            .full       (full_v[i]),
            .fullm1     (fm1_v[i]),
            .parse_done (pd_v[i]),
            .ready_c    (ready_v[i]),
            .sop_take_c (sop_take_v[i]),
            .pkt_end_c  (end_v[i]),
            .drop_c     (drop_v[i]),
            .err_c      (err_v[i]),
            .fifo_reset (fifo_reset_v[i]),
            .fifo_wr    (fifo_wr_v[i]),
            .fifo_wdata (wdata_v[i])
        );
    end

    // Only the selected lane can raise its terms, so OR-ing selects it
    assign hop_in_ready  = |ready_v;
    assign meta_in_ready = |sop_take_v;

    // Dispatch pointer, meta steering, statistics and error flag
    always_comb begin
        wptr_d       = wptr_q ^ (|end_v);
        meta_valid_d = |sop_take_v;
        rci_d        = (|sop_take_v) ? meta_in_rci : rci_q;
        pkt_d        = pkt_q + CNT_W'(|sop_take_v);
        drop_d       = drop_q + CNT_W'(|drop_v);
        err_d        = err_q | (|err_v);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q       <= 1'b0;
            meta_valid_q <= 1'b0;
            rci_q        <= '0;
            pkt_q        <= '0;
            drop_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            wptr_q       <= wptr_d;
            meta_valid_q <= meta_valid_d;
            rci_q        <= rci_d;
            pkt_q        <= pkt_d;
            drop_q       <= drop_d;
            err_q        <= err_d;
        end
    end

    assign hop_fifo_reset0 = fifo_reset_v[0];
    assign hop_fifo_reset1 = fifo_reset_v[1];
    assign hop_fifo_wr0    = fifo_wr_v[0];
    assign hop_fifo_wr1    = fifo_wr_v[1];
    assign hop_fifo_wdata0 = wdata_v[0];
    assign hop_fifo_wdata1 = wdata_v[1];
    assign pp_meta_valid   = meta_valid_q;
    assign pp_meta_rci     = rci_q;
    assign pkt_cnt         = pkt_q;
    assign drop_cnt        = drop_q;
    assign err_sticky      = err_q;

endmodule
